// File: rtl/vending_machine_pkg.sv
// vending_machine_pkg: shared state encoding, coin values and parameter defaults.
//   Provides state_t, coin nickel values, default DEBOUNCE_CYCLES / PRICE_NICKELS,
//   and a saturating 7-bit add used by the credit accumulator.
package vending_machine_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int PRICE_NICKELS_DEFAULT   = 25;

    localparam logic [6:0] NICKELS_ONE_DOLLAR  = 7'd20;
    localparam logic [6:0] NICKELS_FIFTY_CENTS = 7'd10;
    localparam logic [6:0] NICKELS_TEN_CENTS   = 7'd2;
    localparam logic [6:0] NICKELS_FIVE_CENTS  = 7'd1;
    localparam logic [6:0] ACC_MAX             = 7'd127;

    // Credit never wraps: an overflowing sum clamps to the 7-bit maximum.
    function automatic logic [6:0] sat_add(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7] ? ACC_MAX : s[6:0];
    endfunction
endpackage

// File: rtl/vending_machine_if.sv
// vending_machine_if: coin sensor / release bundle between the machine and its environment.
//   Enable, OneDollar, FiftyCents, TenCents, FiveCents : to the machine (raw levels)
//   Rel, OneDollar_d, FiftyCents_d, TenCents_d, FiveCents_d : from the machine
interface vending_machine_if;
    logic Enable;
    logic OneDollar;
    logic FiftyCents;
    logic TenCents;
    logic FiveCents;
    logic Rel;
    logic OneDollar_d;
    logic FiftyCents_d;
    logic TenCents_d;
    logic FiveCents_d;

    modport master (
        output Enable, OneDollar, FiftyCents, TenCents, FiveCents,
        input  Rel, OneDollar_d, FiftyCents_d, TenCents_d, FiveCents_d
    );

    modport slave (
        input  Enable, OneDollar, FiftyCents, TenCents, FiveCents,
        output Rel, OneDollar_d, FiftyCents_d, TenCents_d, FiveCents_d
    );
endinterface

// File: rtl/coin_debouncer.sv
// coin_debouncer: 2-flop synchronizer, stability debouncer and rising-edge pulse for one coin sensor.
//   CLK, RST : clock, synchronous active-high reset
//   raw      : asynchronous bouncing sensor level
//   d        : debounced level
//   pulse    : one-cycle pulse on each debounced 0->1 transition
module coin_debouncer
    import vending_machine_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic d,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2, d_q;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles where the synchronized level disagrees with d;
    // any cycle of agreement (a bounce back) restarts it from zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            d   <= 1'b0;
            d_q <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            d_q <= d;
            if (s2 == d) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                d   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/vending_machine.sv
// vending_machine: debounced coin intake, saturating nickel accumulator and release FSM.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of vending_machine_if (Enable + raw coins in; Rel + debounced coins out)
module vending_machine
    import vending_machine_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int PRICE_NICKELS   = PRICE_NICKELS_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    vending_machine_if.slave   bus
);
    logic [3:0] pulse;
    logic [6:0] coin_sum, acc, acc_next, sum;
    logic       hit;
    state_t     state, state_next;

    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_one_dollar (
        .CLK(CLK), .RST(RST), .raw(bus.OneDollar), .d(bus.OneDollar_d), .pulse(pulse[3]));
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fifty_cents (
        .CLK(CLK), .RST(RST), .raw(bus.FiftyCents), .d(bus.FiftyCents_d), .pulse(pulse[2]));
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ten_cents (
        .CLK(CLK), .RST(RST), .raw(bus.TenCents), .d(bus.TenCents_d), .pulse(pulse[1]));
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_five_cents (
        .CLK(CLK), .RST(RST), .raw(bus.FiveCents), .d(bus.FiveCents_d), .pulse(pulse[0]));

    // Coins pulsing in the same cycle are all credited together (max 33, no overflow here).
    assign coin_sum = (pulse[3] ? NICKELS_ONE_DOLLAR  : 7'd0)
                    + (pulse[2] ? NICKELS_FIFTY_CENTS : 7'd0)
                    + (pulse[1] ? NICKELS_TEN_CENTS   : 7'd0)
                    + (pulse[0] ? NICKELS_FIVE_CENTS  : 7'd0);

    assign hit = bus.Enable && (coin_sum != 7'd0);
    // From IDLE the first coin loads rather than adds, so stale credit never leaks in.
    assign sum = sat_add(state == IDLE ? 7'd0 : acc, coin_sum);

    always_comb begin
        state_next = state;
        acc_next   = acc;
        case (state)
            IDLE, COLLECT: begin
                if (hit) begin
                    acc_next   = sum;
                    state_next = (int'(sum) >= PRICE_NICKELS) ? RELEASE : COLLECT;
                end
            end
            RELEASE: state_next = RELEASE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            acc     <= 7'd0;
            bus.Rel <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            bus.Rel <= (state_next == RELEASE);
        end
    end
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: randomized bouncing-coin stimulus checked against a credit/price reference model.
module tb_vending_machine;
    localparam int N     = 50;
    localparam int PRICE = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vending_machine_if bus();

    vending_machine #(.DEBOUNCE_CYCLES(N), .PRICE_NICKELS(PRICE)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int credit   = 0;
    bit released = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int value(input logic [3:0] m);
        return (m[3] ? 20 : 0) + (m[2] ? 10 : 0) + (m[1] ? 2 : 0) + (m[0] ? 1 : 0);
    endfunction

    function automatic int d_bits();
        return int'({bus.OneDollar_d, bus.FiftyCents_d, bus.TenCents_d, bus.FiveCents_d});
    endfunction

    function automatic int exp_state();
        return released ? 2 : (credit > 0 ? 1 : 0);
    endfunction

    task automatic set_coins(input logic [3:0] m);
        {bus.OneDollar, bus.FiftyCents, bus.TenCents, bus.FiveCents} = m;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_rel"}, int'(bus.Rel), int'(released));
        check({tag, "_acc"}, int'(dut.acc), credit);
        check({tag, "_state"}, int'(dut.state), exp_state());
    endtask

    // One reset edge must clear everything, even with coins held high.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel", int'(bus.Rel), 0);
        check("rst_acc", int'(dut.acc), 0);
        check("rst_state", int'(dut.state), 0);
        check("rst_d", d_bits(), 0);
        rst = 1'b0;
        credit   = 0;
        released = 1'b0;
    endtask

    // Bounce, settle high, check credit after the worst-case latency, then bounce back low.
    task automatic press(input logic [3:0] m, input int bounces);
        for (int b = 0; b < bounces; b++) begin
            set_coins(m);
            wait_cycles($urandom_range(1, 20));
            set_coins(4'b0);
            wait_cycles($urandom_range(1, 20));
        end
        set_coins(m);
        wait_cycles(N + 4);
        if (bus.Enable && !released) begin
            credit = (credit + value(m) > 127) ? 127 : credit + value(m);
            if (credit >= PRICE) released = 1'b1;
        end
        check("d_hi", d_bits(), int'(m));
        check_all("press");
        for (int b = 0; b < bounces; b++) begin
            set_coins(4'b0);
            wait_cycles($urandom_range(1, 20));
            set_coins(m);
            wait_cycles($urandom_range(1, 20));
        end
        set_coins(4'b0);
        wait_cycles(N + 4);
        check("d_lo", d_bits(), 0);
        check_all("unpress");
    endtask

    initial begin
        bus.Enable = 1'b1;
        set_coins(4'b0);
        wait_cycles(2);
        do_reset();

        // Two dollars: first short of price, second releases; later coins are ignored.
        press(4'b1000, 0);
        press(4'b1000, 0);
        press(4'b0001, 2);
        press(4'b0100, 1);
        do_reset();

        // Dollar + fifty cents.
        press(4'b1000, 0);
        press(4'b0100, 0);
        do_reset();

        // Exactly 25 nickels on the final five-cent coin.
        press(4'b1000, 0);
        press(4'b0010, 0);
        press(4'b0010, 0);
        press(4'b0001, 0);
        do_reset();

        // Heavy bouncing must credit a dollar once per press.
        press(4'b1000, 3);
        press(4'b0010, 1);
        do_reset();

        // Disabled: debounced outputs follow, credit stays zero.
        bus.Enable = 1'b0;
        press(4'b0010, 0);
        press(4'b1000, 2);
        bus.Enable = 1'b1;

        // A coin held through reset counts exactly once after it settles.
        set_coins(4'b1000);
        do_reset();
        wait_cycles(N + 4);
        credit = 20;
        check("held_d", d_bits(), 8);
        check_all("held");
        set_coins(4'b0);
        wait_cycles(N + 4);
        check_all("held_off");
        do_reset();

        // All four coins together.
        press(4'b1111, 0);
        do_reset();

        for (int e = 0; e < 15; e++) begin
            int presses;
            presses = $urandom_range(1, 5);
            for (int p = 0; p < presses; p++) begin
                bus.Enable = ($urandom_range(0, 4) != 0);
                press(4'($urandom_range(1, 15)), $urandom_range(0, 3));
            end
            bus.Enable = 1'b1;
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable CLK cycles (10 ms at 50 MHz) before a coin input is accepted.
REQ-002 Parameter PRICE_NICKELS, default 25, item price in 5-cent units ($1.25).
REQ-003 CLK  input  1  system clock, 50 MHz, rising-edge active; single clock domain.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 Enable  input  1  high = coins accepted; low = coin edges ignored.
REQ-006 OneDollar, FiftyCents, TenCents, FiveCents  input  1 each  raw, asynchronous, bouncing coin-sensor levels.
REQ-007 Rel  output  1  release: item is dispensed while high.
REQ-008 OneDollar_d, FiftyCents_d, TenCents_d, FiveCents_d  output  1 each  debounced copies of the coin inputs.

Function
REQ-009 Each coin input SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-010 A debounced output SHALL take the synchronized value only after that value has differed from the current output for DEBOUNCE_CYCLES consecutive cycles.
REQ-011 Any change of the synchronized value before the count completes SHALL restart the count, so 0.4-0.8 ms bounces never propagate.
REQ-012 One coin insertion SHALL be a 0->1 transition of a debounced output, detected as a single-cycle pulse; debounced falling edges SHALL add nothing.
REQ-013 Coin values in nickels SHALL be: OneDollar 20, FiftyCents 10, TenCents 2, FiveCents 1.
REQ-014 The accumulator SHALL be 7 bits wide, in nickels, and saturate at 127 (no wrap-around).
REQ-015 Simultaneous coin pulses in the same cycle SHALL all be added in that cycle.
REQ-016 The FSM SHALL have 2-bit state encoding IDLE=00, COLLECT=01, RELEASE=10; code 11 SHALL go to IDLE.
REQ-017 IDLE: the first accepted coin pulse (Enable=1) SHALL load the accumulator with its value and move to COLLECT, or move directly to RELEASE if that value alone is >= PRICE_NICKELS.
REQ-018 COLLECT: each accepted pulse SHALL add its value; when the next accumulator value is >= PRICE_NICKELS, the FSM SHALL enter RELEASE on that same edge.
REQ-019 RELEASE: Rel SHALL be 1; further coin pulses SHALL be ignored; the state SHALL be held until RST. No change is returned.
REQ-020 Rel SHALL be a registered output equal to (state == RELEASE), so it rises on the clock edge that enters RELEASE.
REQ-021 Latency: at most DEBOUNCE_CYCLES+4 cycles from the last bounce of the completing coin to Rel=1.
REQ-022 With Enable=0, coin pulses SHALL be ignored but debouncers SHALL keep running; the state and accumulator SHALL be held.

Reset
REQ-023 While RST=1 on a CLK edge, the state SHALL be IDLE, the accumulator 0, Rel 0, all synchronizer flops, debounce counters and *_d outputs 0, and edge detectors cleared.
REQ-024 RST asserted mid-collection or during RELEASE SHALL discard credit and deassert Rel on the next edge; reset SHALL take priority over coin pulses in the same cycle.
REQ-025 An input held high through reset deassertion SHALL be debounced afresh and SHALL count as one coin once it becomes stable.

Structure
REQ-026 Package vending_machine_pkg SHALL hold the state encoding, the coin nickel values, and the PRICE_NICKELS and DEBOUNCE_CYCLES defaults.
REQ-027 The synchronizer, debouncer and rising-edge pulse SHALL be one sub-module, coin_debouncer, instantiated four times; the FSM and accumulator SHALL be in the top level.

Verification (DEBOUNCE_CYCLES overridden to 50 for speed)
REQ-028 Reset, Enable=1, two clean OneDollar presses -> first press gives no Rel (20 nickels); second gives Rel=1 (40 nickels, RELEASE).
REQ-029 Reset, OneDollar then FiftyCents -> Rel=1 after FiftyCents is debounced (30 nickels).
REQ-030 Reset, OneDollar, TenCents, TenCents, FiveCents -> Rel stays 0 until the FiveCents pulse (exactly 25 nickels), then Rel=1.
REQ-031 OneDollar pulses 1-3 bounces shorter than DEBOUNCE_CYCLES before a stable high, repeated on release -> OneDollar_d rises exactly once; accumulator +20 exactly once.
REQ-032 Rel=1 then further coins -> Rel remains 1 and the accumulator is unchanged; RST pulse -> Rel=0 and state IDLE on the next edge.
REQ-033 Enable=0 with a clean TenCents press -> TenCents_d toggles, the accumulator stays 0 and Rel stays 0.
